// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the iterative cipher.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned KW = 128 * (NR + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // col[31:24] holds row 0 of the column.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES cipher round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  input  logic         final_round,
  output logic [0:127] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_in[8*i +: 8]);
    end
    // Byte index is 4*column + row; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (final_round) begin
        {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      end else begin
        {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
          mix_column({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
      end
    end
    for (int i = 0; i < 16; i++) begin
      state_out[8*i +: 8] = mc[i] ^ round_key[8*i +: 8];
    end
  end

endmodule

// File: rtl/aes_encrypt_seq.sv
// Iterative AES-128 encryptor: one round per clock through a shared round datapath.
module aes_encrypt_seq
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:127]  in,
  input  logic [0:KW-1] words,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:127]  out
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rc_q, rc_d;
  logic [0:127] st_q, st_d;
  logic [0:127] out_q, out_d;
  logic [0:127] rkey;
  logic [0:127] rnd_out;
  logic         last_rnd;

  // Round-key mux with constant part selects only.
  always_comb begin
    rkey = '0;
    for (int unsigned r = 0; r <= NR; r++) begin
      if (rc_q == 4'(r)) rkey = words[128*r +: 128];
    end
  end

  assign last_rnd = (rc_q == 4'(NR));

  aes_round u_round (
    .state_in    (st_q),
    .round_key   (rkey),
    .final_round (last_rnd),
    .state_out   (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rc_q  <= '0;
      st_q  <= '0;
      out_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      rc_q  <= rc_d;
      st_q  <= st_d;
      out_q <= out_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    rc_d  = rc_q;
    st_d  = st_q;
    out_d = out_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = in ^ words[0:127];
          rc_d  = 4'd1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        st_d = rnd_out;
        if (last_rnd) begin
          out_d = rnd_out;
          fsm_d = DONE;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);
  assign out_valid = (fsm_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_aes_encrypt_seq.sv
// Directed-vector bench for the iterative AES-128 encryptor using FIPS-197 known answers.
module tb_aes_encrypt_seq;
  import aes_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [0:127]  in_blk;
  logic [0:KW-1] words;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [0:127]  out_blk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_q[$];

  localparam logic [0:127] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_blk),
    .words     (words),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_blk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    cyc++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Standard AES-128 key schedule, producing the expanded-key stimulus.
  function automatic logic [0:KW-1] expand(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [0:79]   rcon;
    logic [0:KW-1] res;
    rcon = 80'h01020408102040801b36;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])}
            ^ {rcon[8*(i/4 - 1) +: 8], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string tag, output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      step();
      edges++;
    end
    if (!out_valid) check({tag, " out_valid timeout"}, 128'(out_valid), 128'd1);
  endtask

  task automatic run_block(input string tag, input logic [0:127] key, input logic [0:127] pt,
                           input logic [0:127] ct, input int hold);
    int edges;
    words    = expand(key);
    in_blk   = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, " busy"}, 128'(busy), 128'd1);
    wait_out(tag, edges);
    check({tag, " latency"}, 128'(edges), 128'd10);
    check({tag, " out"}, out_blk, ct);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " hold out"}, out_blk, ct);
      check({tag, " hold out_valid"}, 128'(out_valid), 128'd1);
      check({tag, " hold in_ready"}, 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " in_ready after"}, 128'(in_ready), 128'd1);
    check({tag, " out_valid after"}, 128'(out_valid), 128'd0);
    check({tag, " out kept"}, out_blk, ct);
  endtask

  initial begin
    int edges;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_blk    = '0;
    words     = '0;
    step();
    step();
    rst_n = 1'b1;
    check("reset in_ready", 128'(in_ready), 128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy", 128'(busy), 128'd0);
    check("reset out", out_blk, 128'h0);

    run_block("c1", K_C1, P_C1, C_C1, 0);
    run_block("appb bp", K_B, P_B, C_B, 20);

    // Back-to-back with in_valid held high and the consumer always ready.
    acc_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_blk    = P_C1;
    words     = expand(K_C1);
    step();
    wait_out("b2b first", edges);
    check("b2b first out", out_blk, C_C1);
    step();
    check("b2b in_ready", 128'(in_ready), 128'd1);
    check("b2b single accept", 128'(acc_q.size()), 128'd1);
    in_blk = P_B;
    words  = expand(K_B);
    step();
    in_valid = 1'b0;
    wait_out("b2b second", edges);
    check("b2b second out", out_blk, C_B);
    step();
    out_ready = 1'b0;
    check("b2b accepts", 128'(acc_q.size()), 128'd2);
    if (acc_q.size() == 2) check("b2b interval", 128'(acc_q[1] - acc_q[0]), 128'd12);

    // Reset while round 5 is in flight.
    in_blk   = P_C1;
    words    = expand(K_C1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst out", out_blk, 128'h0);
    check("midrst out_valid", 128'(out_valid), 128'd0);
    check("midrst in_ready", 128'(in_ready), 128'd1);
    check("midrst busy", 128'(busy), 128'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("midrst no pulse", 128'(seen), 128'd0);
    run_block("c1 after rst", K_C1, P_C1, C_C1, 0);

    run_block("zero", 128'h0, 128'h0, C_Z, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_seq.md
# aes_encrypt_seq

Iterative AES-128 encryption sequencer: accepts one 128-bit plaintext block over a valid/ready handshake and computes one cipher round per clock. It reuses a single round datapath and indexes round keys from the 1408-bit expanded-key bus that the key-expansion block produces. The ciphertext is presented over a second valid/ready handshake. It replaces the fully unrolled cipher wherever area matters more than throughput.

## Interface
- NR, 10, number of rounds; only 10 (AES-128) is supported.
- KW, 128*(NR+1) = 1408, expanded-key bus width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  block can accept a plaintext (high only in IDLE).
- in  in  [0:127]  plaintext, byte 0 = bits [0:7], column-major state.
- words  in  [0:KW-1]  expanded key; round key r = words[128*r +: 128].
- busy  out  1  high in ROUND and DONE; `words` must be held stable while high.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts the ciphertext.
- out  out  [0:127]  ciphertext.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid&in_ready: state_q <= in ^ words[0:127], rc <= 1, go to ROUND.
- ROUND:
  - state_q <= aes_round(state_q, round key rc, final = (rc==NR)).
  - rc increments each cycle.
  - When rc==NR: the final round omits MixColumns, out <= result, go to DONE.
- DONE:
  - out_valid=1, out held stable.
  - On out_valid&out_ready: go to IDLE.
  - in_ready stays 0 in DONE. No overlap or pipelining; at most one block in flight.
- Round function: SubBytes, ShiftRows, MixColumns (skipped when final), AddRoundKey, in that order.
  - GF(2^8) arithmetic uses xtime with reduction polynomial 0x11B.
- rc: 4-bit counter, range 1..NR. It never wraps past NR; rc is don't-care outside ROUND and reset to 0.
- `out` keeps the last ciphertext after leaving DONE until the next DONE entry. It is undefined-free: reset to 0.
- Reset (rst_n=0 at any edge, including mid-ROUND or in DONE):
  - FSM → IDLE; state_q, rc, out all 0.
  - In-flight block discarded, no out_valid pulse.
- in_valid while not in IDLE: ignored, not queued.

## Timing
- Accept edge = E0.
- Round r completes at edge E0+r.
- out_valid rises after edge E0+NR, i.e. the first cycle it is visible is NR+1 = 11 cycles after the accept cycle.
- out_valid stays high until the handshake edge. in_ready is high the cycle after that edge.
- Minimum initiation interval: 12 cycles (1 accept + 10 rounds + 1 output handshake cycle with out_ready already high).
- Output registered. in_ready, out_valid and busy are decoded directly from the FSM register, with no combinational path from in_valid/out_ready.
- Reset values: in_ready=1 (IDLE) from the first cycle after reset; out_valid=0; busy=0; out=128'h0.

## Structure
- Package aes_pkg:
  - NR and KW constants.
  - FSM state encoding (IDLE=0, ROUND=1, DONE=2).
  - sbox function (256-entry constant case).
  - xtime and mix_column functions.
- Sub-module aes_round (combinational): ports state_in[0:127], round_key[0:127], final, state_out[0:127].
  - Unit-testable on its own.
- Top holds only the FSM, rc, state_q, the output register and the round-key mux.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff → out 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid is first seen exactly 11 cycles after the accept cycle.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734 → out 3925841d02dc09fbdc118597196a0b32.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid; out stays stable, out_valid stays 1, in_ready stays 0.
  - Then pulse out_ready; in_ready=1 the next cycle.
- Back-to-back: in_valid held high with two blocks (C.1 then App. B, each with its key) and out_ready=1 → both results correct, accepts 12 cycles apart, second in_valid ignored while busy=1.
- Reset mid-operation:
  - Drive rst_n=0 at round 5, then release.
  - Response: out=0, out_valid=0, in_ready=1.
  - A fresh C.1 block then produces 69c4e0d8… with no stale output.
- Zero vector: key 0, in 0 → out 66e94bd4ef8a2c3b884cfa59ca342b2e.
